// File: rtl/mod10_counter_arbiter_if.sv
// mod10_counter_arbiter_if
// Bundles the requester handshake and the shared mod-10 counter control
// signals used by mod10_counter_arbiter.
//
// Signals:
//   req[1:0]        per-requester request, held until done/abort
//   dir[1:0]        per-requester direction (0 = up, 1 = down)
//   steps0, steps1  per-requester step count
//   gnt[1:0]        one-hot grant
//   done[1:0]       one-cycle completion pulse per requester
//   aborted         one-cycle pulse when the granted requester bailed out
//   busy            arbiter is in a run or finishing one
//   cnt_q           current value of the shared counter
//   cnt_load, cnt_load_value, cnt_up_down, cnt_upthendown
//                   control inputs of the shared counter
//
// Modports:
//   master  the arbiter side
//   slave   the requesters plus the counter side
interface mod10_counter_arbiter_if #(
    parameter int STEP_W = 4
);
    logic [1:0]        req;
    logic [1:0]        dir;
    logic [STEP_W-1:0] steps0;
    logic [STEP_W-1:0] steps1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              aborted;
    logic              busy;
    logic [3:0]        cnt_q;
    logic              cnt_load;
    logic [3:0]        cnt_load_value;
    logic              cnt_up_down;
    logic              cnt_upthendown;

    modport master (
        input  req, dir, steps0, steps1, cnt_q,
        output gnt, done, aborted, busy,
        output cnt_load, cnt_load_value, cnt_up_down, cnt_upthendown
    );

    modport slave (
        output req, dir, steps0, steps1, cnt_q,
        input  gnt, done, aborted, busy,
        input  cnt_load, cnt_load_value, cnt_up_down, cnt_upthendown
    );
endinterface

// File: rtl/mod10_counter_arbiter.sv
// mod10_counter_arbiter
// Shares one free-running mod-10 up/down counter between two requesters.
// A granted requester gets exactly N single-step counts in its chosen
// direction; at all other times the counter is frozen by reloading its own
// output. Grants alternate round-robin when both requesters are waiting.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      mod10_counter_arbiter_if.master (requester handshake and
//            counter control, see the interface file)
module mod10_counter_arbiter #(
    parameter int STEP_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mod10_counter_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        gnt_r;
    logic [1:0]        gnt_next;
    logic [1:0]        done_r;
    logic [1:0]        done_next;
    logic              aborted_r;
    logic              aborted_next;
    logic              busy_r;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] remaining_next;
    logic              rr_ptr;
    logic              rr_next;
    logic              dir_lat;
    logic              dir_next;
    logic              owner;
    logic              owner_next;

    logic              winner;
    logic [STEP_W-1:0] win_steps;
    logic              win_dir;
    logic              owner_req;
    logic              run_step;

    // Arbitration: a lone requester always wins; on a tie rr_ptr decides.
    always_comb begin
        winner = 1'b0;
        case (bus.req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = rr_ptr;
            default: winner = 1'b0;
        endcase
        win_steps = winner ? bus.steps1 : bus.steps0;
        win_dir   = bus.dir[winner];
    end

    // The counter only steps while running for an owner that still requests;
    // a dropped request freezes it in the very same cycle.
    assign owner_req = bus.req[owner];
    assign run_step  = (state == RUN) && owner_req;

    assign bus.cnt_load       = ~run_step;
    assign bus.cnt_load_value = bus.cnt_q;
    assign bus.cnt_up_down    = dir_lat;
    assign bus.cnt_upthendown = 1'b0;

    assign bus.gnt     = gnt_r;
    assign bus.done    = done_r;
    assign bus.aborted = aborted_r;
    assign bus.busy    = busy_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt_r     <= 2'b00;
            done_r    <= 2'b00;
            aborted_r <= 1'b0;
            busy_r    <= 1'b0;
            remaining <= '0;
            rr_ptr    <= 1'b0;
            dir_lat   <= 1'b0;
            owner     <= 1'b0;
        end else begin
            state     <= state_next;
            gnt_r     <= gnt_next;
            done_r    <= done_next;
            aborted_r <= aborted_next;
            busy_r    <= (state_next != IDLE);
            remaining <= remaining_next;
            rr_ptr    <= rr_next;
            dir_lat   <= dir_next;
            owner     <= owner_next;
        end
    end

    // done and aborted are pulses: they default low and are only raised on
    // the transition into DONE, so they last exactly that one cycle.
    always_comb begin
        state_next     = state;
        gnt_next       = gnt_r;
        done_next      = 2'b00;
        aborted_next   = 1'b0;
        remaining_next = remaining;
        rr_next        = rr_ptr;
        dir_next       = dir_lat;
        owner_next     = owner;

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    owner_next = winner;
                    dir_next   = win_dir;
                    gnt_next   = winner ? 2'b10 : 2'b01;
                    if (win_steps != '0) begin
                        state_next     = RUN;
                        remaining_next = win_steps;
                    end else begin
                        // Zero-length run completes without touching the counter.
                        state_next = DONE;
                        done_next  = winner ? 2'b10 : 2'b01;
                    end
                end
            end

            RUN: begin
                // A dropped request wins over a final step in the same cycle.
                if (!owner_req) begin
                    state_next   = DONE;
                    aborted_next = 1'b1;
                end else begin
                    remaining_next = remaining - 1'b1;
                    if (remaining == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                        state_next = DONE;
                        done_next  = owner ? 2'b10 : 2'b01;
                    end
                end
            end

            DONE: begin
                gnt_next   = 2'b00;
                rr_next    = ~owner;
                state_next = IDLE;
            end

            default: begin
                gnt_next   = 2'b00;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod10_counter_arbiter.sv
// tb_mod10_counter_arbiter
// Drives mod10_counter_arbiter with directed and random requests. A
// behavioural mod-10 counter sits on the counter side of the interface; the
// expected grant order and counter values come from plain round-robin and
// modulo-10 arithmetic kept in the bench.
module tb_mod10_counter_arbiter;
    localparam int STEP_W = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       preset_en;
    logic [3:0] preset_val;
    logic [3:0] cq;

    int tests_run = 0;
    int failures  = 0;
    int model_q   = 0;
    int model_rr  = 0;

    mod10_counter_arbiter_if #(.STEP_W(STEP_W)) bus ();

    mod10_counter_arbiter #(.STEP_W(STEP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // The shared counter: counts every cycle unless loaded; preset lets the
    // bench put it at a known starting value while the arbiter holds it.
    always @(posedge clk) begin
        if (preset_en)
            cq <= preset_val;
        else if (bus.cnt_load)
            cq <= bus.cnt_load_value;
        else if (bus.cnt_up_down)
            cq <= (cq == 4'd0) ? 4'd9 : cq - 4'd1;
        else
            cq <= (cq == 4'd9) ? 4'd0 : cq + 4'd1;
    end
    assign bus.cnt_q = cq;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int wrap10(input int v);
        return ((v % 10) + 10) % 10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d,
                                 input logic [3:0] s0, input logic [3:0] s1);
        bus.req    = r;
        bus.dir    = d;
        bus.steps0 = s0;
        bus.steps1 = s1;
    endtask

    task automatic presetCounter(input int v);
        preset_en  = 1'b1;
        preset_val = 4'(v);
        tick();
        preset_en  = 1'b0;
        model_q    = v;
    endtask

    // Follows one granted run from grant to the IDLE cycle after DONE.
    // abort_after >= 0 drops the winner's req once that many steps were taken.
    task automatic serveRun(input int exp_w, input int exp_dir, input int exp_steps,
                            input int abort_after);
        logic [1:0] onehot;
        int guard;
        int n;
        bit dropped;
        bit exp_ab;
        int exp_n;

        onehot = (exp_w == 1) ? 2'b10 : 2'b01;
        guard  = 0;
        while (bus.gnt == 2'b00 && guard < 8) begin
            tick();
            guard++;
        end
        checkOutput("grant", bus.gnt, onehot);

        // Fields are captured at grant; scrambling them now must not matter.
        if (exp_w == 0) bus.steps0 = 4'($urandom);
        else            bus.steps1 = 4'($urandom);
        bus.dir[exp_w] = 1'($urandom_range(0, 1));

        n       = 0;
        dropped = 1'b0;
        guard   = 0;
        while (bus.done == 2'b00 && bus.aborted == 1'b0 && guard < 40) begin
            checkOutput("gnt_run", bus.gnt, onehot);
            checkOutput("busy_run", bus.busy, 1);
            checkOutput("upthendown", bus.cnt_upthendown, 0);
            if (abort_after >= 0 && n == abort_after) begin
                bus.req[exp_w] = 1'b0;
                dropped = 1'b1;
            end
            tick();
            guard++;
            if (!dropped) n++;
            checkOutput("q_step", cq, wrap10(model_q + (exp_dir != 0 ? -n : n)));
        end

        exp_ab = (abort_after >= 0) && (abort_after < exp_steps);
        exp_n  = exp_ab ? abort_after : exp_steps;
        checkOutput("steps_taken", n, exp_n);
        checkOutput("done", bus.done, exp_ab ? 2'b00 : onehot);
        checkOutput("aborted", bus.aborted, exp_ab);
        checkOutput("busy_done", bus.busy, 1);
        checkOutput("gnt_done", bus.gnt, onehot);
        model_q  = wrap10(model_q + (exp_dir != 0 ? -exp_n : exp_n));
        checkOutput("q_end", cq, model_q);
        model_rr = 1 - exp_w;

        bus.req[exp_w] = 1'b0;
        tick();
        checkOutput("gnt_clear", bus.gnt, 0);
        checkOutput("done_clear", bus.done, 0);
        checkOutput("aborted_clear", bus.aborted, 0);
        checkOutput("busy_idle", bus.busy, 0);
        checkOutput("q_hold", cq, model_q);
    endtask

    initial begin
        logic [1:0] mask;
        logic [1:0] d;
        logic [3:0] s0;
        logic [3:0] s1;
        int ab0;
        int ab1;
        int first;

        // Reset state
        reset_n    = 1'b0;
        preset_en  = 1'b1;
        preset_val = 4'd0;
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        tick();
        tick();
        checkOutput("rst_gnt", bus.gnt, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_aborted", bus.aborted, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_load", bus.cnt_load, 1);
        reset_n   = 1'b1;
        preset_en = 1'b0;
        model_q   = 0;
        model_rr  = 0;
        tick();

        // Simultaneous requests straight after reset: requester 0 first
        applyStimulus(2'b11, 2'b10, 4'd2, 4'd3);
        serveRun(0, 0, 2, -1);
        serveRun(1, 1, 3, -1);

        // 7 up by 5 -> 8,9,0,1,2
        presetCounter(7);
        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0);
        serveRun(0, 0, 5, -1);

        // 1 down by 3 -> 0,9,8
        presetCounter(1);
        applyStimulus(2'b10, 2'b10, 4'd0, 4'd3);
        serveRun(1, 1, 3, -1);

        // Zero-step request
        applyStimulus(2'b01, 2'b00, 4'd0, 4'd0);
        serveRun(0, 0, 0, -1);

        // Abort after 3 of 8 steps from 0
        presetCounter(0);
        applyStimulus(2'b01, 2'b00, 4'd8, 4'd0);
        serveRun(0, 0, 8, 3);

        // Reset in the middle of a run restores requester 0 priority
        presetCounter(4);
        applyStimulus(2'b01, 2'b00, 4'd9, 4'd0);
        tick();
        checkOutput("grant_pre_reset", bus.gnt, 2'b01);
        tick();
        tick();
        reset_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        tick();
        checkOutput("midrst_gnt", bus.gnt, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        checkOutput("midrst_load", bus.cnt_load, 1);
        reset_n  = 1'b1;
        model_rr = 0;
        presetCounter(5);
        applyStimulus(2'b11, 2'b01, 4'd2, 4'd4);
        serveRun(0, 1, 2, -1);
        serveRun(1, 0, 4, -1);

        // Random scenarios
        for (int t = 0; t < 30; t++) begin
            mask = 2'($urandom_range(1, 3));
            d    = 2'($urandom);
            s0   = 4'($urandom);
            s1   = 4'($urandom);
            ab0  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            ab1  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            applyStimulus(mask, d, s0, s1);
            first = (mask == 2'b11) ? model_rr : ((mask == 2'b10) ? 1 : 0);
            if (first == 0) serveRun(0, int'(d[0]), int'(s0), ab0);
            else            serveRun(1, int'(d[1]), int'(s1), ab1);
            if (mask == 2'b11) begin
                if (first == 0) serveRun(1, int'(d[1]), int'(s1), ab1);
                else            serveRun(0, int'(d[0]), int'(s0), ab0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
